event_input_queue: RTL and testbench
====================================

Name: event_input_queue

Overview:
- Parametrised input stage placed in front of the monitor pipeline (topEntity).
- Captures input-stream events from NUM_INPUTS streams, each with its own new-input flag, and tags each event with a cycle timestamp.
- Buffers events in a ring FIFO and releases one event per start_new_pipeline pulse, only while the pipeline reports pipeline_ready.
- Replaces direct drive of input_x/new_input into the monitor. Back-to-back input bursts no longer depend on the pipeline accepting every cycle.

Parameters:
- NUM_INPUTS, 1, number of input streams per event.
- DATA_W, 64, width of each stream value (signed).
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TS_W, 32, timestamp counter width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; low freezes all state.
- in_data  in  NUM_INPUTS*DATA_W  stream values; stream i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_INPUTS  per-stream new-input flags.
- pipeline_ready  in  1  pipeline can accept a new evaluation this cycle.
- out_data  out  NUM_INPUTS*DATA_W  values of the released event.
- out_present  out  NUM_INPUTS  copy of the released event's in_valid mask.
- out_ts  out  TS_W  timestamp of the released event.
- start_new_pipeline  out  1  one-cycle release strobe; out_* are valid while it is high.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky; set when an event is dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0 except empty = 1.
  - Read pointer, write pointer and timestamp counter cleared.
  - Reset mid-burst discards all queued events; no start_new_pipeline may follow the deassertion unless new input arrives.
- Timestamp:
  - ts increments by 1 every cycle while en = 1, wrapping modulo 2^TS_W.
  - An event carries the ts value of the cycle it is pushed.
- Push: occurs when en = 1 and |in_valid = 1.
  - Stores {in_data, in_valid, ts} at the write pointer.
  - Streams with in_valid = 0 keep their data bits as stored, but consumers must ignore them via out_present.
- Pop: occurs when en = 1, empty = 0 and pipeline_ready = 1.
  - Registered outputs: next cycle start_new_pipeline = 1 and out_* show the head entry.
  - Otherwise start_new_pipeline = 0 and out_* hold their last value.
- Latency: an event pushed into an empty queue at cycle t, with pipeline_ready high, appears at cycle t+2 (push at t, pop at t+1, strobe at t+2). Without the optional feature there is no same-cycle path.
- Throughput: at most one push and one pop per cycle.
- Push and pop in the same cycle:
  - Count is unchanged.
  - Allowed when full; the new event is accepted and is not a drop.
- Full, push and no pop: the event is dropped and overflow is set. overflow clears only on reset.
- Empty with pipeline_ready high: no strobe.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is derived from a separate occupancy counter.
- en low: no push, no pop, ts held, start_new_pipeline forced to 0. An in_valid pulse during en = 0 is lost without setting overflow.

Optional Feature:
- Macro: EVENT_INPUT_QUEUE_BYPASS_EN.
- Defined: when empty = 1, pipeline_ready = 1, en = 1 and a push occurs, the event goes straight to the output registers and is never written to the FIFO.
  - start_new_pipeline rises at t+1 instead of t+2.
  - count stays 0.
- Undefined: every event passes through FIFO storage; latency as in Behaviour.

Decomposition:
- Package event_input_queue_pkg holds:
  - default width constants;
  - a function computing the pointer width;
  - the entry-layout offsets (data, mask, ts field positions within a packed entry).
- One sub-module, event_input_queue_mem:
  - DEPTH x (NUM_INPUTS*(DATA_W+1)+TS_W) register array;
  - synchronous write, asynchronous read.
- Pointers, control and the output registers stay in the top module.

Test Plan:
- Basic, NUM_INPUTS = 1, pipeline_ready held 1: push x = 1 at cycle 5 -> start_new_pipeline high at cycle 7 with out_data = 1, out_present = 1, out_ts = 5.
- Burst: push x = 1..5 on consecutive cycles with pipeline_ready = 0 -> count climbs to 5. Then raise ready -> five strobes on consecutive cycles with out_data 1,2,3,4,5 in order; empty = 1 afterwards.
- Overflow, DEPTH = 8, ready = 0: push 9..18 -> full after the 8th push; the 9th and 10th are dropped and overflow = 1. Draining returns 9..16 only.
- Full with simultaneous push and pop: keep the queue full, ready = 1, push 17 -> count stays 8, overflow stays 0, and 17 later emerges in order.
- Multi-stream and en, NUM_INPUTS = 2: in_valid = 2'b10 with stream1 = 7 -> out_present = 2'b10, out_data[127:64] = 7. en low for 3 cycles -> ts frozen, no strobe.
- Reset mid-operation and bypass: assert rst low with 3 entries queued -> count = 0 and empty = 1 immediately, no strobe after release. With EVENT_INPUT_QUEUE_BYPASS_EN, empty queue and ready = 1, push 42 at t -> strobe at t+1 and count stays 0.

Source files
------------

// File: rtl/event_input_queue_pkg.sv
// Shared constants and entry-layout helpers for the event input queue.
// An entry is packed as {data, mask, ts}, with ts in the least significant bits.
package event_input_queue_pkg;

  localparam int DEF_NUM_INPUTS = 1;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_TS_W       = 32;

  localparam int TS_LSB = 0;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int mask_lsb(input int ts_w);
    return ts_w;
  endfunction

  function automatic int data_lsb(input int num_inputs, input int ts_w);
    return ts_w + num_inputs;
  endfunction

  function automatic int entry_w(input int num_inputs, input int data_w, input int ts_w);
    return num_inputs * (data_w + 1) + ts_w;
  endfunction

endpackage

// File: rtl/event_input_queue_if.sv
// Bus between the event source / pipeline side (master) and the queue (slave).
interface event_input_queue_if
  import event_input_queue_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int TS_W       = DEF_TS_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshake: an event is offered whenever any in_valid bit is high (no back-pressure,
  // drops are flagged by overflow); pipeline_ready gates release, and out_* are valid
  // exactly in the cycle start_new_pipeline is high.
  logic [NUM_INPUTS*DATA_W-1:0] in_data;
  logic [NUM_INPUTS-1:0]        in_valid;
  logic                         pipeline_ready;
  logic [NUM_INPUTS*DATA_W-1:0] out_data;
  logic [NUM_INPUTS-1:0]        out_present;
  logic [TS_W-1:0]              out_ts;
  logic                         start_new_pipeline;
  logic [CNT_W-1:0]             count;
  logic                         full;
  logic                         empty;
  logic                         overflow;

  modport master (
    output in_data, in_valid, pipeline_ready,
    input  out_data, out_present, out_ts, start_new_pipeline, count, full, empty, overflow
  );

  modport slave (
    input  in_data, in_valid, pipeline_ready,
    output out_data, out_present, out_ts, start_new_pipeline, count, full, empty, overflow
  );

endinterface

// File: rtl/event_input_queue_mem.sv
// Entry storage for the event queue: synchronous write, asynchronous read.
module event_input_queue_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 97,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/event_input_queue.sv
// Timestamping event queue in front of the monitor pipeline; one release per ready cycle.
// Optional EVENT_INPUT_QUEUE_BYPASS_EN: an event arriving at an empty, ready queue skips storage.
module event_input_queue
  import event_input_queue_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int TS_W       = DEF_TS_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  event_input_queue_if.slave   q
);

  localparam int PW    = ptr_w(DEPTH);
  localparam int CW    = PW + 1;
  localparam int DW    = NUM_INPUTS * DATA_W;
  localparam int EW    = entry_w(NUM_INPUTS, DATA_W, TS_W);
  localparam int M_LSB = mask_lsb(TS_W);
  localparam int D_LSB = data_lsb(NUM_INPUTS, TS_W);

  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         occ;
  logic [TS_W-1:0]       ts;
  logic                  ovf;
  logic                  strobe;
  logic [DW-1:0]         out_data_r;
  logic [NUM_INPUTS-1:0] out_present_r;
  logic [TS_W-1:0]       out_ts_r;
  logic [EW-1:0]         wdata, rdata;
  logic                  is_empty, is_full;
  logic                  push, pop, byp, push_fifo, drop;

  assign is_empty = (occ == '0);
  assign is_full  = (occ == CW'(DEPTH));

  assign push = en & (|q.in_valid);
  assign pop  = en & ~is_empty & q.pipeline_ready;

`ifdef EVENT_INPUT_QUEUE_BYPASS_EN
  assign byp = push & is_empty & q.pipeline_ready;
`else
  assign byp = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign push_fifo = push & ~byp & (~is_full | pop);
  assign drop      = push & is_full & ~pop;

  assign wdata = {q.in_data, q.in_valid, ts};

  event_input_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push_fifo),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr          <= '0;
      rptr          <= '0;
      occ           <= '0;
      ts            <= '0;
      ovf           <= 1'b0;
      strobe        <= 1'b0;
      out_data_r    <= '0;
      out_present_r <= '0;
      out_ts_r      <= '0;
    end else begin
      if (en)        ts   <= ts + TS_W'(1);
      if (push_fifo) wptr <= wptr + PW'(1);
      if (pop)       rptr <= rptr + PW'(1);
      case ({push_fifo, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (drop) ovf <= 1'b1;
      strobe <= pop | byp;
      if (pop) begin
        out_data_r    <= rdata[D_LSB +: DW];
        out_present_r <= rdata[M_LSB +: NUM_INPUTS];
        out_ts_r      <= rdata[TS_LSB +: TS_W];
      end else if (byp) begin
        out_data_r    <= q.in_data;
        out_present_r <= q.in_valid;
        out_ts_r      <= ts;
      end
    end
  end

  assign q.out_data           = out_data_r;
  assign q.out_present        = out_present_r;
  assign q.out_ts             = out_ts_r;
  assign q.start_new_pipeline = strobe;
  assign q.count              = occ;
  assign q.full               = is_full;
  assign q.empty              = is_empty;
  assign q.overflow           = ovf;

endmodule

// File: tb/tb_event_input_queue.sv
// Bench for event_input_queue: directed scenarios plus random traffic, checked
// against a queue-based reference model through an expected-release scoreboard.
module tb_event_input_queue;
  import event_input_queue_pkg::*;

  localparam int NI    = 2;
  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int TSW   = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EVW   = NI * DW + NI + TSW;
`ifdef EVENT_INPUT_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic rst_chk = 1'b0;
  always #5 clk = ~clk;

  event_input_queue_if #(.NUM_INPUTS(NI), .DATA_W(DW), .DEPTH(DEPTH), .TS_W(TSW)) bus ();

  event_input_queue #(.NUM_INPUTS(NI), .DATA_W(DW), .DEPTH(DEPTH), .TS_W(TSW)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .q   (bus.slave)
  );

  // reference model: stored events and releases expected next cycle
  logic [EVW-1:0] model_q[$];
  logic [EVW-1:0] exp_q[$];
  logic [TSW-1:0] m_ts  = '0;
  bit             m_ovf = 1'b0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk or negedge rst) begin : model
    logic [EVW-1:0] ev;
    if (!rst) begin
      model_q.delete();
      exp_q.delete();
      m_ts  = '0;
      m_ovf = 1'b0;
    end else if (en) begin
      ev = {bus.in_data, bus.in_valid, m_ts};
      if (BYP && model_q.size() == 0 && bus.pipeline_ready && (|bus.in_valid)) begin
        exp_q.push_back(ev);
      end else begin
        if (model_q.size() > 0 && bus.pipeline_ready) exp_q.push_back(model_q.pop_front());
        if (|bus.in_valid) begin
          if (model_q.size() < DEPTH) model_q.push_back(ev);
          else m_ovf = 1'b1;
        end
      end
      m_ts = m_ts + 1;
    end
  end

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // scoreboard monitor
  logic [EVW-1:0] last_out = '0;
  always begin : monitor
    logic [EVW-1:0] got_ev;
    logic [EVW-1:0] exp_ev;
    @(negedge clk or posedge rst_chk);
    got_ev = {bus.out_data, bus.out_present, bus.out_ts};
    if (!rst) begin
      last_out = '0;
      chk("reset_state",
          {got_ev, bus.start_new_pipeline, bus.count, bus.full, bus.empty, bus.overflow},
          {{EVW{1'b0}}, 1'b0, {CW{1'b0}}, 1'b0, 1'b1, 1'b0});
    end else begin
      if (exp_q.size() > 0) begin
        exp_ev = exp_q.pop_front();
        chk("strobe", bus.start_new_pipeline, 1'b1);
        chk("event", got_ev, exp_ev);
        last_out = exp_ev;
      end else begin
        chk("no_strobe", bus.start_new_pipeline, 1'b0);
        chk("hold", got_ev, last_out);
      end
      chk("count", bus.count, model_q.size());
      chk("empty", bus.empty, model_q.size() == 0);
      chk("full", bus.full, model_q.size() == DEPTH);
      chk("overflow", bus.overflow, m_ovf);
    end
  end

  // driver tasks
  task automatic step(input logic e, input logic r, input logic [NI-1:0] v,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    @(negedge clk);
    #2;
    en                 = e;
    bus.pipeline_ready = r;
    bus.in_valid       = v;
    bus.in_data        = {d1, d0};
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, r, '0, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic push1(input logic r, input logic [DW-1:0] x);
    step(1'b1, r, 2'b01, x, {$urandom, $urandom});
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1 rst_chk = 1'b1;
    #1 rst_chk = 1'b0;
    repeat (hold) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    bus.in_data        = '0;
    bus.in_valid       = '0;
    bus.pipeline_ready = 1'b0;
    #3 rst = 1'b0;
    #1 rst_chk = 1'b1;
    #1 rst_chk = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // basic: push at cycle 5 after release, ready held high
    idle(5, 1'b1);
    push1(1'b1, 64'd1);
    idle(3, 1'b1);

    // burst of five while stalled, then drain
    for (int i = 1; i <= 5; i++) push1(1'b0, DW'(i));
    idle(2, 1'b0);
    idle(8, 1'b1);

    // overflow: ten pushes into eight slots
    for (int i = 9; i <= 18; i++) push1(1'b0, DW'(i));
    idle(1, 1'b0);
    idle(10, 1'b1);

    // full queue with simultaneous push and pop
    do_reset(2);
    for (int i = 100; i < 108; i++) push1(1'b0, DW'(i));
    push1(1'b1, 64'd17);
    idle(12, 1'b1);

    // multi-stream mask and enable freeze
    step(1'b1, 1'b1, 2'b10, 64'h0123_4567_89ab_cdef, 64'd7);
    idle(3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b01, 64'd99, 64'd98);
    push1(1'b1, 64'd55);
    idle(3, 1'b1);

    // random traffic with varying ready pressure
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 120; i++) begin
        logic [NI-1:0] v;
        v = ($urandom_range(0, 3) == 0) ? '0 : NI'($urandom_range(1, 3));
        step($urandom_range(0, 9) != 0, $urandom_range(0, 3) < seg + 1, v,
             {$urandom, $urandom}, {$urandom, $urandom});
      end
    end
    idle(12, 1'b1);

    // reset with three entries queued, then quiet
    for (int i = 0; i < 3; i++) push1(1'b0, DW'(200 + i));
    do_reset(2);
    idle(6, 1'b1);

    // empty and ready: direct push (bypass path when enabled)
    push1(1'b1, 64'd42);
    idle(4, 1'b1);

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
